// File: rtl/wts_wave_reader_5ch.sv
// -----------------------------------------------------------------------------
// wts_wave_reader_5ch
//
// Consumer end of the 5-channel tone generator's wave-address stream. Each
// time-multiplexed slot names a channel (A..E = 0..4) and a wave address. The
// block turns that into a wave RAM read, scales the returned signed sample by
// the channel volume, and sums all channels of a frame. Channel E (4) closes
// the frame: the sum, divided by 16 with floor rounding, is presented on
// mixed_out together with a one-cycle mixed_valid strobe.
//
// Pipeline:
//   S1  register the RAM address and tag the slot (channel, valid)
//   S2  wait for the synchronous RAM (one-cycle read latency)
//   S3  scale the returned sample, accumulate, close the frame on channel 4
//
// Ports:
//   clk           in   1   system clock, rising edge
//   nreset        in   1   asynchronous active-low reset
//   active        in   3   slot channel; 0..4 = A..E, 5..7 = idle slot
//   wave_address  in   7   wave address of the slot in 'active'
//   reg_enable    in   5   per-channel enable, bit n = channel n
//   reg_volume_a  in   4   channel A volume (0 = mute)
//   reg_volume_b  in   4   channel B volume
//   reg_volume_c  in   4   channel C volume
//   reg_volume_d  in   4   channel D volume
//   reg_volume_e  in   4   channel E volume
//   mem_address   out  10  wave RAM address {channel, wave_address}, registered
//   mem_rdata     in   8   signed RAM sample, valid one cycle after mem_address
//   mixed_out     out  11  signed mixed frame sample
//   mixed_valid   out  1   one-cycle pulse when mixed_out updates
// -----------------------------------------------------------------------------
module wts_wave_reader_5ch (
  input  logic        clk,
  input  logic        nreset,
  input  logic [2:0]  active,
  input  logic [6:0]  wave_address,
  input  logic [4:0]  reg_enable,
  input  logic [3:0]  reg_volume_a,
  input  logic [3:0]  reg_volume_b,
  input  logic [3:0]  reg_volume_c,
  input  logic [3:0]  reg_volume_d,
  input  logic [3:0]  reg_volume_e,
  output logic [9:0]  mem_address,
  input  logic [7:0]  mem_rdata,
  output logic [10:0] mixed_out,
  output logic        mixed_valid
);

  localparam logic [2:0] LAST_CH = 3'd4;

  // ---------------------------------------------------------------------------
  // Stage S1: address register and slot tag
  // ---------------------------------------------------------------------------
  logic [9:0] mem_address_q, mem_address_d;
  logic       s1_valid_q,    s1_valid_d;
  logic [2:0] s1_ch_q,       s1_ch_d;
  logic       slot_is_ch;

  assign slot_is_ch = (active <= LAST_CH);

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    mem_address_d = mem_address_q;  // idle slots leave the RAM address alone
    s1_valid_d    = 1'b0;
    s1_ch_d       = s1_ch_q;
    if (slot_is_ch) begin
      mem_address_d = {active, wave_address};
      s1_valid_d    = 1'b1;
      s1_ch_d       = active;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage S2: the RAM performs its read; only the tag moves forward
  // ---------------------------------------------------------------------------
  logic       s2_valid_q, s2_valid_d;
  logic [2:0] s2_ch_q,    s2_ch_d;

  always_comb begin
    s2_valid_d = s1_valid_q;
    s2_ch_d    = s1_ch_q;
  end

  // ---------------------------------------------------------------------------
  // Stage S3: scale, accumulate, close frame
  // ---------------------------------------------------------------------------
  logic               sel_enable;
  logic [3:0]         sel_volume;
  logic signed [12:0] sample_ext;
  logic signed [12:0] volume_ext;
  logic signed [12:0] term;
  logic signed [14:0] acc_q, acc_d;
  logic signed [14:0] acc_sum;
  logic               frame_close;
  logic [10:0]        mixed_out_q, mixed_out_d;
  logic               mixed_valid_q, mixed_valid_d;

  // Volume and enable are looked up at the S3 edge, so a register write only
  // affects channels that have not yet reached S3.
  always_comb begin
    sel_enable = 1'b0;
    sel_volume = 4'd0;
    case (s2_ch_q)
      3'd0: begin sel_enable = reg_enable[0]; sel_volume = reg_volume_a; end
      3'd1: begin sel_enable = reg_enable[1]; sel_volume = reg_volume_b; end
      3'd2: begin sel_enable = reg_enable[2]; sel_volume = reg_volume_c; end
      3'd3: begin sel_enable = reg_enable[3]; sel_volume = reg_volume_d; end
      3'd4: begin sel_enable = reg_enable[4]; sel_volume = reg_volume_e; end
      default: ;
    endcase
  end

  // Signed sample times unsigned volume: the volume is zero-extended so the
  // product stays a signed 13-bit value (-1920..+1905).
  assign sample_ext = {{5{mem_rdata[7]}}, mem_rdata};
  assign volume_ext = $signed({9'd0, sel_volume});
  assign term       = sel_enable ? (sample_ext * volume_ext) : 13'sd0;

  // Five terms of at most |1920| fit in 15 signed bits without overflow.
  assign acc_sum     = acc_q + {{2{term[12]}}, term};
  assign frame_close = s2_valid_q && (s2_ch_q == LAST_CH);

  always_comb begin
    acc_d         = acc_q;
    mixed_out_d   = mixed_out_q;
    mixed_valid_d = 1'b0;
    if (s2_valid_q) begin
      if (frame_close) begin
        // Dropping the low four bits of a two's-complement value is an
        // arithmetic shift with floor rounding; bits [14:4] are the 11-bit
        // result, which cannot exceed -600..+595.
        mixed_out_d   = acc_sum[14:4];
        mixed_valid_d = 1'b1;
        acc_d         = '0;  // next frame starts from zero
      end else begin
        acc_d = acc_sum;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register, independent of
  // statement or process order.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      mem_address_q <= '0;
      s1_valid_q    <= 1'b0;
      s1_ch_q       <= '0;
      s2_valid_q    <= 1'b0;
      s2_ch_q       <= '0;
      acc_q         <= '0;
      mixed_out_q   <= '0;
      mixed_valid_q <= 1'b0;
    end else begin
      mem_address_q <= mem_address_d;
      s1_valid_q    <= s1_valid_d;
      s1_ch_q       <= s1_ch_d;
      s2_valid_q    <= s2_valid_d;
      s2_ch_q       <= s2_ch_d;
      acc_q         <= acc_d;
      mixed_out_q   <= mixed_out_d;
      mixed_valid_q <= mixed_valid_d;
    end
  end

  assign mem_address = mem_address_q;
  assign mixed_out   = mixed_out_q;
  assign mixed_valid = mixed_valid_q;

endmodule

// File: tb/tb_wts_wave_reader_5ch.sv
// -----------------------------------------------------------------------------
// tb_wts_wave_reader_5ch
//
// Self-checking bench for wts_wave_reader_5ch. A behavioural wave RAM answers
// mem_address one cycle later. Slot sequences are queued and run through
// run_seq, which predicts, for every cycle, mem_address, mixed_valid and
// mixed_out from the frame rules (sum of sample*volume over enabled channels,
// closed by channel 4, floor-divided by 16) and compares the DUT against it.
// -----------------------------------------------------------------------------
module tb_wts_wave_reader_5ch;

  logic        clk = 1'b0;
  logic        nreset;
  logic [2:0]  active;
  logic [6:0]  wave_address;
  logic [4:0]  reg_enable;
  logic [3:0]  vol [5];
  logic [9:0]  mem_address;
  logic [7:0]  mem_rdata;
  logic [10:0] mixed_out;
  logic        mixed_valid;

  int checks = 0;
  int errors = 0;

  logic signed [7:0] ram [1024];

  // Reference model state carried between sequences.
  int mdl_acc  = 0;
  int mdl_out  = 0;
  int mdl_addr = 0;

  int q_ch[$];
  int q_addr[$];

  always #5 clk = ~clk;

  // Synchronous wave RAM, one-cycle read latency.
  always @(posedge clk) mem_rdata <= ram[mem_address];

  wts_wave_reader_5ch dut (
    .clk          (clk),
    .nreset       (nreset),
    .active       (active),
    .wave_address (wave_address),
    .reg_enable   (reg_enable),
    .reg_volume_a (vol[0]),
    .reg_volume_b (vol[1]),
    .reg_volume_c (vol[2]),
    .reg_volume_d (vol[3]),
    .reg_volume_e (vol[4]),
    .mem_address  (mem_address),
    .mem_rdata    (mem_rdata),
    .mixed_out    (mixed_out),
    .mixed_valid  (mixed_valid)
  );

  // ---------------------------------------------------------------------------
  // Reference model helpers
  // ---------------------------------------------------------------------------
  function automatic int floor16(input int s);
    int r;
    r = s % 16;
    if (r < 0) r += 16;
    return (s - r) / 16;
  endfunction

  function automatic int term_of(input int ch, input int addr);
    int smp;
    if (!reg_enable[ch]) return 0;
    smp = ram[ch * 128 + addr];
    return smp * int'(vol[ch]);
  endfunction

  task automatic push_slot(input int ch, input int addr);
    q_ch.push_back(ch);
    q_addr.push_back(addr);
  endtask

  task automatic set_all_vol(input int v);
    for (int c = 0; c < 5; c++) vol[c] = 4'(v);
  endtask

  task automatic fill_all_ch(input int addr, input int sample);
    for (int c = 0; c < 5; c++) ram[c * 128 + addr] = 8'(sample);
  endtask

  // Runs the queued slots followed by three idle cycles that drain the
  // pipeline; checks all three outputs after every rising edge.
  task automatic run_seq(input string name);
    int n;
    int cur;
    int cl[];
    int co[];
    int eo[];
    int ea[];
    logic [10:0] want_out;
    logic [9:0]  want_addr;
    logic        want_valid;

    n  = q_ch.size();
    cl = new[n + 3];
    co = new[n + 3];
    eo = new[n + 3];
    ea = new[n + 3];
    cur = mdl_out;

    for (int i = 0; i < n; i++) begin
      if (q_ch[i] <= 4) begin
        mdl_addr = q_ch[i] * 128 + q_addr[i];
        mdl_acc += term_of(q_ch[i], q_addr[i]);
        if (q_ch[i] == 4) begin
          mdl_out   = floor16(mdl_acc);
          mdl_acc   = 0;
          cl[i + 2] = 1;
          co[i + 2] = mdl_out;
        end
      end
      ea[i] = mdl_addr;
    end
    for (int i = n; i < n + 3; i++) ea[i] = mdl_addr;
    for (int j = 0; j < n + 3; j++) begin
      if (cl[j] != 0) cur = co[j];
      eo[j] = cur;
    end

    for (int j = 0; j < n + 3; j++) begin
      if (j < n) begin
        active       = 3'(q_ch[j]);
        wave_address = 7'(q_addr[j]);
      end else begin
        active       = 3'd7;
        wave_address = 7'($urandom);
      end
      @(posedge clk);
      #1;
      want_valid = (cl[j] != 0);
      want_out   = 11'(eo[j]);
      want_addr  = 10'(ea[j]);
      checks++;
      if (mixed_valid !== want_valid) begin
        errors++;
        $display("FAIL %s step %0d mixed_valid got %b want %b", name, j, mixed_valid, want_valid);
      end
      checks++;
      if (mixed_out !== want_out) begin
        errors++;
        $display("FAIL %s step %0d mixed_out got %0d want %0d", name, j, $signed(mixed_out), $signed(want_out));
      end
      checks++;
      if (mem_address !== want_addr) begin
        errors++;
        $display("FAIL %s step %0d mem_address got %0d want %0d", name, j, mem_address, want_addr);
      end
    end
    q_ch.delete();
    q_addr.delete();
  endtask

  task automatic check_out_const(input string name, input int want);
    logic [10:0] w;
    w = 11'(want);
    checks++;
    if (mixed_out !== w) begin
      errors++;
      $display("FAIL %s mixed_out got %0d want %0d", name, $signed(mixed_out), want);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    nreset = 1'b0;
    #7;
    @(posedge clk);
    #2;
    checks++;
    if (mem_address !== 10'd0) begin
      errors++;
      $display("FAIL reset mem_address got %0d want 0", mem_address);
    end
    checks++;
    if (mixed_out !== 11'd0) begin
      errors++;
      $display("FAIL reset mixed_out got %0d want 0", mixed_out);
    end
    checks++;
    if (mixed_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset mixed_valid got %b want 0", mixed_valid);
    end
    @(negedge clk);
    nreset = 1'b1;
  endtask

  task automatic test_basic_frame();
    reg_enable = 5'h1f;
    set_all_vol(15);
    fill_all_ch(5, 10);
    for (int c = 0; c < 5; c++) push_slot(c, 5);
    run_seq("basic_frame");
    check_out_const("basic_frame_value", 46);
  endtask

  task automatic test_extremes();
    reg_enable = 5'h1f;
    set_all_vol(15);
    fill_all_ch(20, -128);
    for (int c = 0; c < 5; c++) push_slot(c, 20);
    run_seq("extreme_neg");
    check_out_const("extreme_neg_value", -600);

    fill_all_ch(21, 127);
    for (int c = 0; c < 5; c++) push_slot(c, 21);
    run_seq("extreme_pos");
    check_out_const("extreme_pos_value", 595);

    set_all_vol(1);
    fill_all_ch(22, 0);
    ram[22] = -8'sd1;
    for (int c = 0; c < 5; c++) push_slot(c, 22);
    run_seq("floor_minus_one");
    check_out_const("floor_minus_one_value", -1);
  endtask

  task automatic test_enable_mute();
    reg_enable = 5'b00001;
    set_all_vol(15);
    vol[0] = 4'd8;
    fill_all_ch(30, 50);
    ram[30] = 8'sd64;
    for (int c = 0; c < 5; c++) push_slot(c, 30);
    run_seq("enable_only_a");
    check_out_const("enable_only_a_value", 32);

    vol[0] = 4'd0;
    for (int c = 0; c < 5; c++) push_slot(c, 30);
    run_seq("mute_a");
    check_out_const("mute_a_value", 0);
  endtask

  task automatic test_idle_order();
    int order[7] = '{2, 6, 0, 7, 1, 3, 4};
    reg_enable = 5'h1f;
    set_all_vol(1);
    fill_all_ch(40, 16);
    for (int k = 0; k < 7; k++) push_slot(order[k], (order[k] <= 4) ? 40 : int'($urandom_range(0, 127)));
    run_seq("idle_order");
    check_out_const("idle_order_value", 5);
  endtask

  task automatic test_back_to_back();
    reg_enable = 5'h1f;
    set_all_vol(4);
    fill_all_ch(50, 16);
    fill_all_ch(51, 0);
    for (int c = 0; c < 5; c++) push_slot(c, 50);
    for (int c = 0; c < 5; c++) push_slot(c, 51);
    run_seq("back_to_back");
    check_out_const("back_to_back_second", 0);
  endtask

  task automatic test_random();
    int len;
    for (int a = 64; a < 128; a++)
      for (int c = 0; c < 5; c++) ram[c * 128 + a] = 8'($urandom);
    for (int it = 0; it < 25; it++) begin
      reg_enable = 5'($urandom);
      for (int c = 0; c < 5; c++) vol[c] = 4'($urandom);
      len = $urandom_range(4, 24);
      for (int k = 0; k < len; k++) push_slot($urandom_range(0, 7), $urandom_range(64, 127));
      if ($urandom_range(0, 1) == 1) push_slot(4, $urandom_range(64, 127));
      run_seq($sformatf("random_%0d", it));
    end
  endtask

  task automatic test_reset_mid_frame();
    reg_enable = 5'h1f;
    set_all_vol(1);
    fill_all_ch(60, 16);
    for (int c = 0; c < 5; c++) push_slot(c, 60);
    run_seq("pre_reset_frame");

    for (int c = 0; c < 3; c++) begin
      active       = 3'(c);
      wave_address = 7'd60;
      @(posedge clk);
      #1;
    end
    active = 3'd7;
    @(posedge clk);
    #3;
    nreset = 1'b0;
    #1;
    checks++;
    if (mixed_out !== 11'd0) begin
      errors++;
      $display("FAIL reset_mid mixed_out got %0d want 0", $signed(mixed_out));
    end
    checks++;
    if (mixed_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid mixed_valid got %b want 0", mixed_valid);
    end
    checks++;
    if (mem_address !== 10'd0) begin
      errors++;
      $display("FAIL reset_mid mem_address got %0d want 0", mem_address);
    end
    @(negedge clk);
    @(negedge clk);
    nreset   = 1'b1;
    mdl_acc  = 0;
    mdl_out  = 0;
    mdl_addr = 0;

    for (int k = 0; k < 4; k++) push_slot(7, 0);
    run_seq("post_reset_idle");
    for (int c = 0; c < 5; c++) push_slot(c, 60);
    run_seq("post_reset_frame");
    check_out_const("post_reset_frame_value", 5);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'sd0;
    nreset       = 1'b1;
    active       = 3'd7;
    wave_address = 7'd0;
    reg_enable   = 5'h1f;
    set_all_vol(15);
    #1;

    test_reset();
    test_basic_frame();
    test_extremes();
    test_enable_mute();
    test_idle_order();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
